// File: rtl/led_pwm_pkg.sv
// Shared definitions for the AHB-lite LED PWM controller: register word offsets
// (haddr[4:2]), CTRL bit positions and the per-channel breathing state type.
package led_pwm_pkg;

   // Register word offsets, decoded from haddr[4:2]
   localparam logic [2:0] AddrCtrl     = 3'd0;
   localparam logic [2:0] AddrPrescale = 3'd1;
   localparam logic [2:0] AddrPeriod   = 3'd2;
   localparam logic [2:0] AddrDuty0    = 3'd3;
   localparam logic [2:0] AddrDuty1    = 3'd4;
   localparam logic [2:0] AddrStatus   = 3'd5;

   // CTRL field positions
   localparam int unsigned CtrlW        = 5;
   localparam int unsigned CtrlEn0      = 0;
   localparam int unsigned CtrlEn1      = 1;
   localparam int unsigned CtrlBreathe0 = 2;
   localparam int unsigned CtrlBreathe1 = 3;
   localparam int unsigned CtrlIrqEn    = 4;

   typedef enum logic [1:0] {
      OFF,
      UP,
      DOWN
   } breathe_state_t;

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM output channel: active (shadow) duty, breathing FSM and registered compare.
// The active duty only changes on a period wrap, so the output never glitches mid-period.
//   clk_i, rst_i  clock and asynchronous active-high reset
//   wrap_i        one-cycle pulse on the clock where the period counter wraps to 0
//   en_i          channel enable (CTRL.en_n)
//   breathe_i     breathing mode request (CTRL.breathe_n)
//   duty_i        programmed DUTYn register
//   period_i      period that is active from this wrap onwards
//   cnt_i         current PWM counter value
//   led_o         registered PWM output
module led_pwm_chan
   import led_pwm_pkg::*;
#(
   parameter int unsigned CntW = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wrap_i,
   input  logic            en_i,
   input  logic            breathe_i,
   input  logic [CntW-1:0] duty_i,
   input  logic [CntW-1:0] period_i,
   input  logic [CntW-1:0] cnt_i,
   output logic            led_o
);

   // One extra bit so the breathing ceiling period+1 fits for an all-ones period
   localparam int unsigned DutyW = CntW + 1;

   breathe_state_t   state_q, state_d;
   logic [DutyW-1:0] duty_act_q, duty_act_d;
   logic [DutyW-1:0] duty_top, duty_inc, duty_dec, duty_load;
   logic             led_q, led_d;

   always_comb begin : breathe_next
      duty_top  = {1'b0, period_i} + DutyW'(1);
      duty_load = {1'b0, duty_i};
      // Saturating steps; a shrunk period clamps an out-of-range duty to the new ceiling
      duty_inc  = (duty_act_q >= duty_top) ? duty_top : duty_act_q + DutyW'(1);
      if (duty_act_q > duty_top) begin
         duty_dec = duty_top;
      end else if (duty_act_q == '0) begin
         duty_dec = '0;
      end else begin
         duty_dec = duty_act_q - DutyW'(1);
      end

      state_d    = state_q;
      duty_act_d = duty_act_q;
      if (wrap_i) begin
         case (state_q)
            OFF: begin
               if (breathe_i) begin
                  duty_act_d = duty_inc;
                  state_d    = (duty_inc == duty_top) ? DOWN : UP;
               end else begin
                  duty_act_d = duty_load;
               end
            end
            UP: begin
               if (!breathe_i) begin
                  state_d    = OFF;
                  duty_act_d = duty_load;
               end else begin
                  duty_act_d = duty_inc;
                  if (duty_inc == duty_top) state_d = DOWN;
               end
            end
            DOWN: begin
               if (!breathe_i) begin
                  state_d    = OFF;
                  duty_act_d = duty_load;
               end else begin
                  duty_act_d = duty_dec;
                  if (duty_dec == '0) state_d = UP;
               end
            end
            default: begin
               state_d    = OFF;
               duty_act_d = duty_load;
            end
         endcase
      end

      // duty 0 never matches; duty above the period always matches
      led_d = en_i & ({1'b0, cnt_i} < duty_act_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= OFF;
         duty_act_q <= '0;
         led_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_act_q <= duty_act_d;
         led_q      <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/led_ahb_pwm.sv
// AHB-lite memory-mapped two-channel LED PWM controller with breathing ramps and a
// period-wrap interrupt. Zero wait state, always OKAY.
//   sys_clock, reset         clock and asynchronous active-high reset
//   mem_ahb_*                AHB-lite slave port (htrans, hready, hwrite, haddr, hwdata in;
//                            hreadyout, hresp, hrdata out)
//   LED_D2, LED_D3           PWM outputs for channel 0 and channel 1
//   irq                      level interrupt, STATUS.wrap & CTRL.irq_en
module led_ahb_pwm
   import led_pwm_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned PRE_W = 16
) (
   input  logic        sys_clock,
   input  logic        reset,
   input  logic [1:0]  mem_ahb_htrans,
   input  logic        mem_ahb_hready,
   input  logic        mem_ahb_hwrite,
   input  logic [31:0] mem_ahb_haddr,
   input  logic [31:0] mem_ahb_hwdata,
   output logic        mem_ahb_hreadyout,
   output logic        mem_ahb_hresp,
   output logic [31:0] mem_ahb_hrdata,
   output logic        LED_D2,
   output logic        LED_D3,
   output logic        irq
);

   // Programmable registers
   logic [CtrlW-1:0] ctrl_q, ctrl_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] duty0_q, duty0_d;
   logic [CNT_W-1:0] duty1_q, duty1_d;
   logic             status_q, status_d;

   // Bus pipeline
   logic [2:0]  addr_q, addr_d;
   logic        wr_pend_q, wr_pend_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rd_val;
   logic        accept, status_clr;

   // Timebase
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_act_q, period_act_d;
   logic             tick, wrap;

   always_comb begin : bus_read_mux
      rd_val = '0;
      case (mem_ahb_haddr[4:2])
         AddrCtrl:     rd_val[CtrlW-1:0] = ctrl_q;
         AddrPrescale: rd_val[PRE_W-1:0] = prescale_q;
         AddrPeriod:   rd_val[CNT_W-1:0] = period_q;
         AddrDuty0:    rd_val[CNT_W-1:0] = duty0_q;
         AddrDuty1:    rd_val[CNT_W-1:0] = duty1_q;
         AddrStatus:   rd_val[0]         = status_q;
         default:      rd_val            = '0;
      endcase
   end

   always_comb begin : bus_next
      accept    = mem_ahb_hready & mem_ahb_htrans[1];
      addr_d    = accept ? mem_ahb_haddr[4:2] : addr_q;
      wr_pend_d = accept & mem_ahb_hwrite;
      // Read value is captured at the address phase, so a write committing on the
      // same edge is not yet visible to it
      rdata_d   = (accept & ~mem_ahb_hwrite) ? rd_val : '0;

      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      period_d   = period_q;
      duty0_d    = duty0_q;
      duty1_d    = duty1_q;
      status_clr = 1'b0;
      if (wr_pend_q) begin
         case (addr_q)
            AddrCtrl:     ctrl_d     = mem_ahb_hwdata[CtrlW-1:0];
            AddrPrescale: prescale_d = mem_ahb_hwdata[PRE_W-1:0];
            AddrPeriod:   period_d   = mem_ahb_hwdata[CNT_W-1:0];
            AddrDuty0:    duty0_d    = mem_ahb_hwdata[CNT_W-1:0];
            AddrDuty1:    duty1_d    = mem_ahb_hwdata[CNT_W-1:0];
            AddrStatus:   status_clr = mem_ahb_hwdata[0];
            default:      ;
         endcase
      end
      // A wrap in the same cycle as the W1C wins
      status_d = (status_q & ~status_clr) | wrap;
   end

   always_comb begin : timer_next
      // >= rather than == keeps the counters bounded if the limit shrinks under them
      tick      = (pre_cnt_q >= prescale_q);
      wrap      = tick & (cnt_q >= period_act_q);
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
      cnt_d     = cnt_q;
      if (wrap) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      period_act_d = wrap ? period_q : period_act_q;
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         ctrl_q       <= '0;
         prescale_q   <= '0;
         period_q     <= '1;
         duty0_q      <= '0;
         duty1_q      <= '0;
         status_q     <= 1'b0;
         addr_q       <= '0;
         wr_pend_q    <= 1'b0;
         rdata_q      <= '0;
         pre_cnt_q    <= '0;
         cnt_q        <= '0;
         period_act_q <= '1;
      end else begin
         ctrl_q       <= ctrl_d;
         prescale_q   <= prescale_d;
         period_q     <= period_d;
         duty0_q      <= duty0_d;
         duty1_q      <= duty1_d;
         status_q     <= status_d;
         addr_q       <= addr_d;
         wr_pend_q    <= wr_pend_d;
         rdata_q      <= rdata_d;
         pre_cnt_q    <= pre_cnt_d;
         cnt_q        <= cnt_d;
         period_act_q <= period_act_d;
      end
   end

   led_pwm_chan #(
      .CntW (CNT_W)
   ) u_chan0 (
      .clk_i     (sys_clock),
      .rst_i     (reset),
      .wrap_i    (wrap),
      .en_i      (ctrl_q[CtrlEn0]),
      .breathe_i (ctrl_q[CtrlBreathe0]),
      .duty_i    (duty0_q),
      .period_i  (period_act_d),
      .cnt_i     (cnt_q),
      .led_o     (LED_D2)
   );

   led_pwm_chan #(
      .CntW (CNT_W)
   ) u_chan1 (
      .clk_i     (sys_clock),
      .rst_i     (reset),
      .wrap_i    (wrap),
      .en_i      (ctrl_q[CtrlEn1]),
      .breathe_i (ctrl_q[CtrlBreathe1]),
      .duty_i    (duty1_q),
      .period_i  (period_act_d),
      .cnt_i     (cnt_q),
      .led_o     (LED_D3)
   );

   assign mem_ahb_hreadyout = 1'b1;
   assign mem_ahb_hresp     = 1'b0;
   assign mem_ahb_hrdata    = rdata_q;
   assign irq               = status_q & ctrl_q[CtrlIrqEn];

   // Address/data bits outside the decoded fields are intentionally ignored
   logic unused_bus_bits;
   assign unused_bus_bits = ^{mem_ahb_haddr, mem_ahb_hwdata, mem_ahb_htrans[0]};

endmodule

// File: tb/tb_led_ahb_pwm.sv
// Self-checking bench for led_ahb_pwm. Bus reads push their expected data into a
// scoreboard queue; a monitor pops and compares when the data phase arrives.
// LED and irq behaviour is checked against cycle positions relative to an observed
// period start.
module tb_led_ahb_pwm;

   logic        sys_clock = 1'b0;
   logic        reset     = 1'b1;
   logic [1:0]  htrans    = 2'b00;
   logic        hready    = 1'b1;
   logic        hwrite    = 1'b0;
   logic [31:0] haddr     = '0;
   logic [31:0] hwdata    = '0;
   logic        hreadyout, hresp;
   logic [31:0] hrdata;
   logic        LED_D2, LED_D3, irq;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] exp_rd_q[$];
   string       tag_q[$];
   logic        mon_rd;

   int breathe_exp[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

   localparam logic [31:0] OffCtrl     = 32'h00;
   localparam logic [31:0] OffPrescale = 32'h04;
   localparam logic [31:0] OffPeriod   = 32'h08;
   localparam logic [31:0] OffDuty0    = 32'h0C;
   localparam logic [31:0] OffDuty1    = 32'h10;
   localparam logic [31:0] OffStatus   = 32'h14;

   led_ahb_pwm dut (
      .sys_clock         (sys_clock),
      .reset             (reset),
      .mem_ahb_htrans    (htrans),
      .mem_ahb_hready    (hready),
      .mem_ahb_hwrite    (hwrite),
      .mem_ahb_haddr     (haddr),
      .mem_ahb_hwdata    (hwdata),
      .mem_ahb_hreadyout (hreadyout),
      .mem_ahb_hresp     (hresp),
      .mem_ahb_hrdata    (hrdata),
      .LED_D2            (LED_D2),
      .LED_D3            (LED_D3),
      .irq               (irq)
   );

   always #5 sys_clock = ~sys_clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clock);
      #1;
      cyc++;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
      htrans = 2'b10;
      hwrite = 1'b1;
      haddr  = a;
      tick();
      htrans = 2'b00;
      hwrite = 1'b0;
      hwdata = d;
      tick();
   endtask

   task automatic ahb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      exp_rd_q.push_back(exp);
      tag_q.push_back(tag);
      htrans = 2'b10;
      hwrite = 1'b0;
      haddr  = a;
      tick();
      htrans = 2'b00;
   endtask

   // Advance until LED_D2 goes 0->1; leaves the bench on the first high sample
   task automatic wait_led2_rise(input string tag, input int bound);
      int   n;
      logic prev;
      logic found;
      n = 0;
      do begin
         prev = LED_D2;
         tick();
         n++;
         found = LED_D2 & ~prev;
      end while (!found && n < bound);
      check_eq({tag, "_rise_seen"}, 32'(found), 32'd1);
   endtask

   task automatic count_led2(input int len, output int highs);
      highs = 0;
      for (int j = 0; j < len; j++) begin
         highs += int'(LED_D2);
         tick();
      end
   endtask

   // Scoreboard monitor: data phase follows an accepted read address phase
   initial begin
      forever begin
         @(posedge sys_clock);
         mon_rd = !reset && hready && htrans[1] && !hwrite;
         #1;
         if (mon_rd && !reset) begin
            if (exp_rd_q.size() == 0) begin
               check_eq("rd_unexpected", 32'(exp_rd_q.size()), 32'd1);
            end else begin
               check_eq(tag_q.pop_front(), hrdata, exp_rd_q.pop_front());
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int highs;

      // Reset state
      repeat (3) @(posedge sys_clock);
      #1;
      reset = 1'b0;
      check_eq("rst_led2", 32'(LED_D2), 32'd0);
      check_eq("rst_led3", 32'(LED_D3), 32'd0);
      check_eq("rst_irq", 32'(irq), 32'd0);
      check_eq("rst_hrdata", hrdata, 32'd0);
      check_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
      check_eq("rst_hresp", 32'(hresp), 32'd0);
      for (int i = 0; i < 8; i++) begin
         ahb_read($sformatf("rst_rd_%0d", i), 32'(i * 4), (i == 2) ? 32'h0000_FFFF : 32'h0);
      end

      // Basic PWM: 3 of 10 clocks high once the first wrap loads PERIOD/DUTY0
      ahb_write(OffPrescale, 32'd0);
      ahb_write(OffPeriod, 32'd9);
      ahb_write(OffDuty0, 32'd3);
      ahb_write(OffCtrl, 32'h1);
      wait_led2_rise("pwm_first_wrap", 70000);
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         check_eq($sformatf("pwm_d3_%0d", i), 32'(LED_D2), 32'((i % 10) < 3));
         tick();
      end
      check_eq("pwm_led3_off", 32'(LED_D3), 32'd0);

      // Mid-period DUTY0 write holds until the next wrap, then 10 > 9 means always on
      cyc = 0;
      ahb_write(OffDuty0, 32'd10);
      while (cyc < 30) begin
         check_eq($sformatf("midper_%0d", cyc), 32'(LED_D2), 32'((cyc < 3) || (cyc >= 10)));
         tick();
      end

      // Duty 0 means always off
      ahb_write(OffDuty0, 32'd0);
      repeat (25) tick();
      count_led2(10, highs);
      check_eq("duty0_zero", 32'(highs), 32'd0);

      // Interrupt: rise after wrap, W1C clears, W1C on a wrap edge loses to the set
      ahb_write(OffDuty0, 32'd3);
      wait_led2_rise("irq_sync", 40);
      cyc = 0;
      ahb_write(OffStatus, 32'h1);
      ahb_write(OffCtrl, 32'h11);
      while (cyc < 9) begin
         check_eq($sformatf("irq_low_%0d", cyc), 32'(irq), 32'd0);
         tick();
      end
      check_eq("irq_rise", 32'(irq), 32'd1);
      ahb_write(OffStatus, 32'h1);
      check_eq("irq_w1c", 32'(irq), 32'd0);
      wait_to(18);
      check_eq("irq_pre_wrap2", 32'(irq), 32'd0);
      tick();
      check_eq("irq_wrap2", 32'(irq), 32'd1);
      tick();
      ahb_write(OffStatus, 32'h1);
      check_eq("irq_w1c2", 32'(irq), 32'd0);
      wait_to(27);
      ahb_write(OffStatus, 32'h1);
      check_eq("irq_w1c_vs_wrap", 32'(irq), 32'd1);
      tick();
      check_eq("irq_w1c_vs_wrap_hold", 32'(irq), 32'd1);

      // Breathing on a 4-tick period: highs per period track duty_act0
      ahb_write(OffPeriod, 32'd3);
      ahb_write(OffDuty0, 32'd0);
      repeat (25) tick();
      ahb_write(OffCtrl, 32'h5);
      wait_led2_rise("breathe_sync", 20);
      cyc = 0;
      for (int k = 0; k < 9; k++) begin
         count_led2(4, highs);
         check_eq($sformatf("breathe_w%0d", k), 32'(highs), 32'(breathe_exp[k]));
      end
      ahb_write(OffCtrl, 32'h1);
      wait_to(44);
      count_led2(12, highs);
      check_eq("breathe_off_reload", 32'(highs), 32'd0);

      // Write then immediately read DUTY1: old value, then new value
      htrans = 2'b10;
      hwrite = 1'b1;
      haddr  = OffDuty1;
      tick();
      hwdata = 32'h0000_1234;
      hwrite = 1'b0;
      exp_rd_q.push_back(32'h0);
      tag_q.push_back("b2b_old");
      tick();
      exp_rd_q.push_back(32'h0000_1234);
      tag_q.push_back("b2b_new");
      tick();
      htrans = 2'b00;
      tick();
      check_eq("b2b_led3_off", 32'(LED_D3), 32'd0);

      // Asynchronous reset in the middle of a transfer
      ahb_write(OffDuty0, 32'd4);
      ahb_write(OffCtrl, 32'h11);
      repeat (12) tick();
      check_eq("pre_rst_led2", 32'(LED_D2), 32'd1);
      check_eq("pre_rst_irq", 32'(irq), 32'd1);
      ahb_read("pre_rst_rd_period", OffPeriod, 32'd3);
      htrans = 2'b10;
      hwrite = 1'b1;
      haddr  = OffDuty1;
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_led2", 32'(LED_D2), 32'd0);
      check_eq("arst_led3", 32'(LED_D3), 32'd0);
      check_eq("arst_irq", 32'(irq), 32'd0);
      check_eq("arst_hrdata", hrdata, 32'd0);
      htrans = 2'b00;
      hwrite = 1'b0;
      hwdata = 32'h0000_BEEF;
      tick();
      reset = 1'b0;
      ahb_read("post_rst_ctrl", OffCtrl, 32'h0);
      ahb_read("post_rst_duty0", OffDuty0, 32'h0);
      ahb_read("post_rst_duty1", OffDuty1, 32'h0);
      ahb_read("post_rst_period", OffPeriod, 32'h0000_FFFF);
      ahb_read("post_rst_status", OffStatus, 32'h0);
      tick();
      check_eq("sb_drained", 32'(exp_rd_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
